seq_adder_sub: RTL and testbench

Parametrised, clocked successor to the board-level 8-bit two-operand adder. Operands are entered from slide switches with a debounced pushbutton under a small state machine. The block supports add, subtract and running-accumulate modes, with carry/borrow and signed-overflow flags. A, B and the result drive banks of active-low seven-segment displays on the DE-series board top level.

---
 rtl/seq_adder_pkg.sv | 25 ++
 rtl/seven_seg_hex.sv | 11 +
 rtl/seq_adder_sub.sv | 152 +++++++++++++++
 tb/tb_seq_adder_sub.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and constants for the sequential adder/subtractor block.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;

  // Active-low segments, bit order g..a = [6:0]
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n holds the glyph for hex digit n (listed F down to 0)
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seven_seg_hex.sv
// One hex nibble to one active-low seven-segment digit.
module seven_seg_hex
  import seq_adder_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seq_adder_sub.sv
// Switch-entry adder/subtractor/accumulator with debounced enter key,
// carry/borrow and signed-overflow flags, and seven-segment displays.
module seq_adder_sub
  import seq_adder_pkg::*;
#(
  parameter int W = 8,
  parameter int DB_CYCLES = 500000,
  localparam int DIGITS = (W + 3) / 4
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY0,
  input  logic                  KEY1,
  input  logic [W-1:0]          SW,
  input  logic [1:0]            MODE,
  output logic [3:0]            LEDR,
  output logic [7*DIGITS-1:0]   HEX_A,
  output logic [7*DIGITS-1:0]   HEX_B,
  output logic [7*DIGITS-1:0]   HEX_S
);

  localparam int PADW = 4 * DIGITS;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          key_meta;
  logic          key_sync;
  logic          key_level;
  logic [CW-1:0] db_cnt;
  logic          press;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  s_reg;
  logic          carry;
  logic          ovf;

  logic          acc_mode;
  logic          do_sub;
  logic [W-1:0]  op_x;
  logic [W-1:0]  op_y;
  logic [W:0]    result;
  logic          res_carry;
  logic          res_ovf;

  // Two-flop synchroniser for the asynchronous pushbutton; idles released (high)
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= KEY1;
      key_sync <= key_meta;
    end
  end

  // Accept a new level after DB_CYCLES consecutive differing samples; pulse once on press
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      key_level <= 1'b1;
      db_cnt    <= '0;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync == key_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_level <= key_sync;
        db_cnt    <= '0;
        press     <= ~key_sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Operand selection and W+1-bit arithmetic with carry/borrow and signed overflow
  always_comb begin
    acc_mode  = (MODE == MODE_ACC);
    do_sub    = (MODE == MODE_SUB);
    op_x      = acc_mode ? s_reg : a_reg;
    op_y      = SW;
    result    = do_sub ? ({1'b0, op_x} - {1'b0, op_y})
                       : ({1'b0, op_x} + {1'b0, op_y});
    res_carry = result[W];
    if (do_sub) begin
      res_ovf = (op_x[W-1] != op_y[W-1]) && (result[W-1] != op_x[W-1]);
    end else begin
      res_ovf = (op_x[W-1] == op_y[W-1]) && (result[W-1] != op_x[W-1]);
    end
  end

  // Entry state machine and operand/result registers, advanced only by press
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state <= S_A;
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (press) begin
      if (acc_mode) begin
        a_reg <= s_reg;
        b_reg <= SW;
        s_reg <= result[W-1:0];
        carry <= res_carry;
        ovf   <= res_ovf;
        state <= S_RES;
      end else begin
        case (state)
          S_A: begin
            a_reg <= SW;
            state <= S_B;
          end
          S_B: begin
            b_reg <= SW;
            s_reg <= result[W-1:0];
            carry <= res_carry;
            ovf   <= res_ovf;
            state <= S_RES;
          end
          default: begin
            a_reg <= SW;
            b_reg <= '0;
            s_reg <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            state <= S_B;
          end
        endcase
      end
    end
  end

  assign LEDR = {state == S_B, state == S_A, ovf, carry};

  logic [PADW-1:0] a_pad;
  logic [PADW-1:0] b_pad;
  logic [PADW-1:0] s_pad;

  assign a_pad = PADW'(a_reg);
  assign b_pad = PADW'(b_reg);
  assign s_pad = PADW'(s_reg);

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    seven_seg_hex u_hex_a (.nibble(a_pad[4*d +: 4]), .seg(HEX_A[7*d +: 7]));
    seven_seg_hex u_hex_b (.nibble(b_pad[4*d +: 4]), .seg(HEX_B[7*d +: 7]));
    seven_seg_hex u_hex_s (.nibble(s_pad[4*d +: 4]), .seg(HEX_S[7*d +: 7]));
  end

endmodule

// File: tb/tb_seq_adder_sub.sv
// Directed self-checking bench for seq_adder_sub (W=8, DB_CYCLES=4).
module tb_seq_adder_sub;

  logic        CLOCK_50;
  logic        KEY0;
  logic        KEY1;
  logic [7:0]  SW;
  logic [1:0]  MODE;
  logic [3:0]  LEDR;
  logic [13:0] HEX_A;
  logic [13:0] HEX_B;
  logic [13:0] HEX_S;

  int compared = 0;
  int mismatched = 0;

  seq_adder_sub #(.W(8), .DB_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50),
    .KEY0(KEY0),
    .KEY1(KEY1),
    .SW(SW),
    .MODE(MODE),
    .LEDR(LEDR),
    .HEX_A(HEX_A),
    .HEX_B(HEX_B),
    .HEX_S(HEX_S)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Hand-written active-low glyphs, g..a
  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction

  function automatic logic [13:0] hex2(input logic [7:0] v);
    hex2 = {seg(v[7:4]), seg(v[3:0])};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic reset_pulse();
    @(negedge CLOCK_50);
    KEY0 = 1'b0;
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    cycles(2);
  endtask

  task automatic press_key(input logic [7:0] val);
    SW = val;
    KEY1 = 1'b0;
    cycles(12);
    KEY1 = 1'b1;
    cycles(12);
  endtask

  task automatic test_reset();
    KEY0 = 1'b0;
    cycles(3);
    compared++;
    if (LEDR !== 4'b0100) begin
      mismatched++;
      $display("[TB] FAIL reset_ledr: got %b expected %b", LEDR, 4'b0100);
    end
    compared++;
    if ({HEX_A, HEX_B, HEX_S} !== {hex2(8'h00), hex2(8'h00), hex2(8'h00)}) begin
      mismatched++;
      $display("[TB] FAIL reset_hex: got %h %h %h expected all %h", HEX_A, HEX_B, HEX_S, hex2(8'h00));
    end
    KEY0 = 1'b1;
    cycles(2);
    MODE = 2'b00;
    press_key(8'h12);
    compared++;
    if (LEDR !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_state: got %b expected %b", LEDR, 4'b1000);
    end
    @(negedge CLOCK_50);
    KEY0 = 1'b0;
    cycles(2);
    compared++;
    if (LEDR !== 4'b0100 || HEX_A !== hex2(8'h00)) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset: got LEDR %b HEX_A %h expected %b %h", LEDR, HEX_A, 4'b0100, hex2(8'h00));
    end
    KEY0 = 1'b1;
    cycles(2);
  endtask

  task automatic test_add();
    MODE = 2'b00;
    press_key(8'h7F);
    compared++;
    if (LEDR !== 4'b1000 || HEX_A !== hex2(8'h7F)) begin
      mismatched++;
      $display("[TB] FAIL add_load_a: got LEDR %b HEX_A %h expected %b %h", LEDR, HEX_A, 4'b1000, hex2(8'h7F));
    end
    press_key(8'h85);
    compared++;
    if ({HEX_A, HEX_B, HEX_S} !== {hex2(8'h7F), hex2(8'h85), hex2(8'h04)}) begin
      mismatched++;
      $display("[TB] FAIL add_result: got %h %h %h expected %h %h %h", HEX_A, HEX_B, HEX_S, hex2(8'h7F), hex2(8'h85), hex2(8'h04));
    end
    // S_RES clears both waiting bits; carry=1, ovf=0
    compared++;
    if (LEDR !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL add_flags: got %b expected %b", LEDR, 4'b0001);
    end
  endtask

  task automatic test_sub();
    MODE = 2'b01;
    press_key(8'h10);
    compared++;
    if (LEDR !== 4'b1000 || HEX_B !== hex2(8'h00) || HEX_S !== hex2(8'h00) || HEX_A !== hex2(8'h10)) begin
      mismatched++;
      $display("[TB] FAIL sub_restart: got LEDR %b A %h B %h S %h", LEDR, HEX_A, HEX_B, HEX_S);
    end
    press_key(8'h20);
    compared++;
    if (HEX_S !== hex2(8'hF0) || LEDR !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL sub_borrow: got S %h LEDR %b expected %h %b", HEX_S, LEDR, hex2(8'hF0), 4'b0001);
    end
    press_key(8'h80);
    press_key(8'h01);
    compared++;
    if (HEX_S !== hex2(8'h7F) || LEDR !== 4'b0010) begin
      mismatched++;
      $display("[TB] FAIL sub_overflow: got S %h LEDR %b expected %h %b", HEX_S, LEDR, hex2(8'h7F), 4'b0010);
    end
  endtask

  task automatic test_accumulate();
    reset_pulse();
    MODE = 2'b10;
    press_key(8'h60);
    compared++;
    if (HEX_S !== hex2(8'h60) || HEX_B !== hex2(8'h60) || HEX_A !== hex2(8'h00) || LEDR !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL acc_first: got A %h B %h S %h LEDR %b", HEX_A, HEX_B, HEX_S, LEDR);
    end
    press_key(8'h60);
    compared++;
    if (HEX_S !== hex2(8'hC0) || LEDR !== 4'b0010) begin
      mismatched++;
      $display("[TB] FAIL acc_second: got S %h LEDR %b expected %h %b", HEX_S, LEDR, hex2(8'hC0), 4'b0010);
    end
    press_key(8'h60);
    compared++;
    if (HEX_S !== hex2(8'h20) || HEX_A !== hex2(8'hC0) || LEDR !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL acc_third: got A %h S %h LEDR %b expected %h %h %b", HEX_A, HEX_S, LEDR, hex2(8'hC0), hex2(8'h20), 4'b0001);
    end
    MODE = 2'b01;
    SW = 8'hFF;
    cycles(10);
    compared++;
    if (HEX_S !== hex2(8'h20) || LEDR !== 4'b0001) begin
      mismatched++;
      $display("[TB] FAIL mode_no_press: got S %h LEDR %b expected %h %b", HEX_S, LEDR, hex2(8'h20), 4'b0001);
    end
  endtask

  task automatic test_debounce();
    reset_pulse();
    MODE = 2'b00;
    SW = 8'hAA;
    KEY1 = 1'b0;
    cycles(3);
    KEY1 = 1'b1;
    cycles(15);
    compared++;
    if (LEDR !== 4'b0100 || HEX_A !== hex2(8'h00)) begin
      mismatched++;
      $display("[TB] FAIL db_short: got LEDR %b HEX_A %h expected %b %h", LEDR, HEX_A, 4'b0100, hex2(8'h00));
    end
    SW = 8'h3C;
    KEY1 = 1'b0;
    cycles(200);
    KEY1 = 1'b1;
    cycles(15);
    compared++;
    if (LEDR !== 4'b1000 || HEX_A !== hex2(8'h3C)) begin
      mismatched++;
      $display("[TB] FAIL db_hold: got LEDR %b HEX_A %h expected %b %h", LEDR, HEX_A, 4'b1000, hex2(8'h3C));
    end
    SW = 8'h5A;
    KEY1 = 1'b0;
    cycles(2);
    KEY1 = 1'b1;
    cycles(1);
    KEY1 = 1'b0;
    cycles(10);
    KEY1 = 1'b1;
    cycles(15);
    // 0x3C + 0x5A = 0x96: no carry, positive operands give negative sum
    compared++;
    if (HEX_B !== hex2(8'h5A) || HEX_S !== hex2(8'h96) || LEDR !== 4'b0010) begin
      mismatched++;
      $display("[TB] FAIL db_bounce: got B %h S %h LEDR %b expected %h %h %b", HEX_B, HEX_S, LEDR, hex2(8'h5A), hex2(8'h96), 4'b0010);
    end
  endtask

  task automatic test_reset_mid_op();
    reset_pulse();
    MODE = 2'b00;
    press_key(8'h33);
    compared++;
    if (LEDR !== 4'b1000 || HEX_A !== hex2(8'h33)) begin
      mismatched++;
      $display("[TB] FAIL midop_load: got LEDR %b HEX_A %h expected %b %h", LEDR, HEX_A, 4'b1000, hex2(8'h33));
    end
    reset_pulse();
    compared++;
    if (LEDR !== 4'b0100 || HEX_A !== hex2(8'h00)) begin
      mismatched++;
      $display("[TB] FAIL midop_reset: got LEDR %b HEX_A %h expected %b %h", LEDR, HEX_A, 4'b0100, hex2(8'h00));
    end
    press_key(8'h55);
    compared++;
    if (LEDR !== 4'b1000 || HEX_A !== hex2(8'h55) || HEX_B !== hex2(8'h00)) begin
      mismatched++;
      $display("[TB] FAIL midop_after: got LEDR %b A %h B %h expected %b %h %h", LEDR, HEX_A, HEX_B, 4'b1000, hex2(8'h55), hex2(8'h00));
    end
    SW = 8'h99;
    KEY1 = 1'b0;
    cycles(4);
    KEY0 = 1'b0;
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    KEY1 = 1'b1;
    cycles(15);
    compared++;
    if (LEDR !== 4'b0100 || HEX_A !== hex2(8'h00)) begin
      mismatched++;
      $display("[TB] FAIL reset_during_db: got LEDR %b HEX_A %h expected %b %h", LEDR, HEX_A, 4'b0100, hex2(8'h00));
    end
  endtask

  initial begin
    KEY0 = 1'b0;
    KEY1 = 1'b1;
    SW = 8'h00;
    MODE = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_accumulate();
    test_debounce();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
